// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the depth-8 FIFO read/write side helpers.
//   - rd_state_e : packer state encoding (FILL collects words, HOLD presents
//                  a row downstream).
//   - FIFO_LANE  : part-select helper giving lane k of width w inside a
//                  packed row, lane 0 in the least significant bits.
// ---------------------------------------------------------------------------
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_LANE(k, w) ((k) * (w)) +: (w)

package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } rd_state_e;

endpackage

`endif

// File: rtl/fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer
// Pops simd*bw-wide words from a show-ahead FIFO and packs `pack` consecutive
// words into one row, presented on a valid/ready handshake. A flush emits the
// current partial row (unfilled lanes read as zero).
//
// Ports:
//   clk        : clock (FIFO read clock)
//   rst_n      : asynchronous active-low reset
//   fifo_empty : FIFO empty flag (registered inside the FIFO)
//   fifo_data  : FIFO head word, valid while fifo_empty = 0
//   fifo_rd    : pop strobe to the FIFO
//   i_flush    : single-cycle request to emit the partial row
//   i_ready    : downstream accepts the row
//   o_valid    : row valid
//   o_data     : packed row, lane k at [(k+1)*simd*bw-1 : k*simd*bw]
//   o_cnt      : number of valid lanes in o_data (1..pack)
//   o_busy     : lanes captured or a row is pending
// ---------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int bw   = 4,
    parameter int simd = 1,
    parameter int pack = 8,
    localparam int cw  = $clog2(pack) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic [simd*bw-1:0]         fifo_data,
    output logic                       fifo_rd,
    input  logic                       i_flush,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [pack*simd*bw-1:0]    o_data,
    output logic [cw-1:0]              o_cnt,
    output logic                       o_busy
);

    localparam int LW = simd * bw;
    localparam int RW = pack * LW;
    localparam logic [cw-1:0] PACK_C = cw'(pack);

    rd_state_e         state_r;
    rd_state_e         state_nxt_s;
    logic [cw-1:0]     cnt_r;
    logic [cw-1:0]     cnt_nxt_s;
    logic              gap_r;
    logic              hs_s;
    logic              enter_hold_s;
    logic [RW-1:0]     row_nxt_s;

    // The FIFO empty flag lags its read pointer by a cycle, so the gap bit
    // forbids a pop in the cycle right after a pop. Reset masks the strobe so
    // nothing is popped while the packer is held in reset.
    assign fifo_rd = rst_n & (state_r == FILL) & ~fifo_empty & ~gap_r;
    assign o_busy  = (cnt_r != {cw{1'b0}}) | o_valid;

    // Next-state decode: count after this edge, handshake, and HOLD entry.
    always_comb begin
        cnt_nxt_s    = cnt_r + {{(cw-1){1'b0}}, fifo_rd};
        hs_s         = o_valid & i_ready;
        enter_hold_s = 1'b0;
        state_nxt_s  = state_r;
        case (state_r)
            FILL: begin
                // A pop coinciding with flush is part of the emitted row.
                if ((fifo_rd && (cnt_nxt_s == PACK_C)) ||
                    (i_flush && (cnt_nxt_s != {cw{1'b0}}))) begin
                    enter_hold_s = 1'b1;
                    state_nxt_s  = HOLD;
                end else begin
                    state_nxt_s  = FILL;
                end
            end
            HOLD: begin
                if (hs_s) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // Lane storage: each lane loads when the pop targets its index; the row
    // presented on HOLD entry already includes the word popped on that edge.
    for (genvar k = 0; k < pack; k++) begin : g_lane
        localparam logic [cw-1:0] K_C = cw'(k);
        logic [LW-1:0] lane_r;
        logic          load_s;

        assign load_s = fifo_rd & (cnt_r == K_C);
        assign row_nxt_s[`FIFO_LANE(k, LW)] = load_s ? fifo_data : lane_r;

        // Lane register: cleared on reset and on row handshake.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_r <= {LW{1'b0}};
            end else if ((state_r == HOLD) && hs_s) begin
                lane_r <= {LW{1'b0}};
            end else if (load_s) begin
                lane_r <= fifo_data;
            end else begin
                lane_r <= lane_r;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
            cnt_r   <= {cw{1'b0}};
            gap_r   <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= {RW{1'b0}};
            o_cnt   <= {cw{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            gap_r   <= fifo_rd;
            if ((state_r == HOLD) && hs_s) begin
                cnt_r   <= {cw{1'b0}};
                o_valid <= 1'b0;
                o_data  <= {RW{1'b0}};
                o_cnt   <= {cw{1'b0}};
            end else if (enter_hold_s) begin
                cnt_r   <= cnt_nxt_s;
                o_valid <= 1'b1;
                o_data  <= row_nxt_s;
                o_cnt   <= cnt_nxt_s;
            end else begin
                cnt_r   <= cnt_nxt_s;
                o_valid <= o_valid;
                o_data  <= o_data;
                o_cnt   <= o_cnt;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_packer
// Bench for fifo_rd_packer (bw=4, simd=1, pack=8). A queue models the FIFO;
// expected rows are queued as stimulus is planned and compared when the DUT
// hands a row over.
// ---------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int BW   = 4;
    localparam int SIMD = 1;
    localparam int PACK = 8;
    localparam int LW   = BW * SIMD;
    localparam int DW   = PACK * LW;
    localparam int CW   = $clog2(PACK) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [LW-1:0] fifo_data;
    logic          fifo_rd;
    logic          i_flush;
    logic          i_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_cnt;
    logic          o_busy;

    fifo_rd_packer #(.bw(BW), .simd(SIMD), .pack(PACK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .i_flush    (i_flush),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_cnt      (o_cnt),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [LW-1:0] fifo_q[$];
    logic [LW-1:0] rowq[$];
    logic [DW-1:0] exp_data_q[$];
    logic [CW-1:0] exp_cnt_q[$];

    logic          smp_rd, smp_valid, smp_busy;
    logic [DW-1:0] smp_data;
    logic [CW-1:0] smp_cnt;
    int            smp_cyc;
    logic          prev_rd   = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] held_data;
    logic [CW-1:0] held_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? {LW{1'b0}} : fifo_q[0];
    endtask

    task automatic push_word(input logic [LW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    // Turn the planned words in rowq into one expected row.
    task automatic push_row();
        logic [DW-1:0] d;
        d = {DW{1'b0}};
        for (int i = 0; i < rowq.size(); i++) begin
            d = d | (DW'(rowq[i]) << (LW * i));
        end
        exp_data_q.push_back(d);
        exp_cnt_q.push_back(CW'(rowq.size()));
        rowq.delete();
    endtask

    // One clock: sample and check at negedge, pop the model FIFO after posedge.
    task automatic cycle();
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        @(negedge clk);
        smp_rd    = fifo_rd;
        smp_valid = o_valid;
        smp_data  = o_data;
        smp_cnt   = o_cnt;
        smp_busy  = o_busy;
        smp_cyc   = cyc;
        check("b2b_pop", smp_rd & prev_rd, 1'b0);
        check("pop_when_empty", smp_rd & fifo_empty, 1'b0);
        if (prev_hold) begin
            check("hold_valid", smp_valid, 1'b1);
            check("hold_data", smp_data, held_data);
            check("hold_cnt", smp_cnt, held_cnt);
        end
        if (smp_valid && i_ready) begin
            check("row_expected", exp_data_q.size() != 0, 1'b1);
            if (exp_data_q.size() != 0) begin
                ed = exp_data_q.pop_front();
                ec = exp_cnt_q.pop_front();
                check("row_data", smp_data, ed);
                check("row_cnt", smp_cnt, ec);
            end
        end
        prev_hold = smp_valid & ~i_ready;
        held_data = smp_data;
        held_cnt  = smp_cnt;
        prev_rd   = smp_rd;
        @(posedge clk);
        #1;
        if (smp_rd && (fifo_q.size() != 0)) begin
            void'(fifo_q.pop_front());
        end
        refresh();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
        end
    endtask

    task automatic flush_now();
        push_row();
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        refresh();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, {DW{1'b0}});
        check("rst_cnt", o_cnt, {CW{1'b0}});
        check("rst_rd", fifo_rd, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: full row, ready high, pop cadence and valid timing
        for (int i = 1; i <= 8; i++) begin
            push_word(LW'(i));
            rowq.push_back(LW'(i));
        end
        push_row();
        cyc = 0;
        for (int i = 0; i < 18; i++) begin
            cycle();
            check("t1_rd", smp_rd, (smp_cyc % 2 == 0) && (smp_cyc <= 14));
            check("t1_valid", smp_valid, smp_cyc == 15);
        end

        // 2: back-pressure holds the row; FIFO keeps its remaining words
        for (int i = 1; i <= 10; i++) begin
            push_word(LW'(i));
        end
        for (int i = 1; i <= 8; i++) begin
            rowq.push_back(LW'(i));
        end
        push_row();
        i_ready = 1'b0;
        run(16);
        check("t2_valid_up", smp_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t2_valid", smp_valid, 1'b1);
            check("t2_rd", smp_rd, 1'b0);
            check("t2_busy", smp_busy, 1'b1);
            check("t2_fifo_left", fifo_q.size(), 2);
        end
        i_ready = 1'b1;
        cycle();
        cycle();
        check("t2_pop_after_hs", smp_rd, 1'b1);
        run(6);
        rowq.push_back(4'd9);
        rowq.push_back(4'd10);
        flush_now();
        run(3);
        check("t2_idle_busy", smp_busy, 1'b0);

        // 3: partial row by flush, then flush with nothing captured
        push_word(4'hA);
        push_word(4'hB);
        push_word(4'hC);
        rowq.push_back(4'hA);
        rowq.push_back(4'hB);
        rowq.push_back(4'hC);
        run(8);
        check("t3_busy", smp_busy, 1'b1);
        flush_now();
        run(3);
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t3_no_row", smp_valid, 1'b0);
            check("t3_no_busy", smp_busy, 1'b0);
        end

        // 4: flush on the same cycle as the 5th pop
        for (int i = 1; i <= 8; i++) begin
            push_word(LW'(i));
        end
        for (int i = 1; i <= 5; i++) begin
            rowq.push_back(LW'(i));
        end
        run(8);
        push_row();
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
        check("t4_pop_with_flush", smp_rd, 1'b1);
        cycle();
        check("t4_valid", smp_valid, 1'b1);
        check("t4_cnt", smp_cnt, 4'd5);
        run(10);
        rowq.push_back(4'd6);
        rowq.push_back(4'd7);
        rowq.push_back(4'd8);
        flush_now();
        run(3);

        // 5: slow producer, one word every 5 cycles
        begin
            logic [LW-1:0] words [8];
            int            idx;
            int            pops;
            words = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h7, 4'hE, 4'h1, 4'hF};
            for (int i = 0; i < 8; i++) begin
                rowq.push_back(words[i]);
            end
            push_row();
            idx  = 0;
            pops = 0;
            for (int k = 0; k < 45; k++) begin
                if ((k % 5 == 0) && (idx < 8)) begin
                    push_word(words[idx]);
                    idx++;
                end
                cycle();
                if (smp_rd) begin
                    pops++;
                end
            end
            check("t5_pops", pops, 8);
            run(4);
        end

        // 6: asynchronous reset mid-row
        for (int i = 1; i <= 8; i++) begin
            push_word(LW'(i));
        end
        run(7);
        #2;
        check("t6_busy_pre", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", o_valid, 1'b0);
        check("t6_busy", o_busy, 1'b0);
        check("t6_rd", fifo_rd, 1'b0);
        check("t6_data", o_data, {DW{1'b0}});
        run(2);
        rst_n = 1'b1;
        check("t6_fifo_left", fifo_q.size(), 4);
        for (int i = 5; i <= 8; i++) begin
            rowq.push_back(LW'(i));
        end
        run(8);
        flush_now();
        run(3);

        check("rows_left", exp_data_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
